// File: rtl/disp_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver:
// segment bit positions, active-low hex font and scanner state encoding.
package disp_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Glyphs on {g,f,e,d,c,b,a}, 0 = lit; b and d are lower case
    localparam logic [6:0] FONT_N [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_e;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational 4-bit hex value to active-low 7-segment glyph lookup.
module seg7_hex_decode
    import disp_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg_n
);

    // Font table lookup; every 4-bit code has a glyph
    always_comb begin
        seg_n = FONT_N[value];
    end

endmodule

// File: rtl/disp_scan_driver.sv
// Free-running anode scanner for a common-anode 7-segment bank with
// per-slot blanking and frame-aligned double-buffered display data.
module disp_scan_driver
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [4*NUM_DIGITS-1:0]   digit_data,
    input  logic [NUM_DIGITS-1:0]     dp,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    input  logic                      load,
    output logic [NUM_DIGITS-1:0]     an_n,
    output logic [7:0]                seg_n,
    output logic                      frame_start,
    output logic                      load_pending
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(CLK_DIV);

    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam scan_state_e      SLOT_ENTRY = (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;

    scan_state_e              state_r, state_nx_s;
    logic [IDX_W-1:0]         idx_r, idx_nx_s;
    logic [CNT_W-1:0]         cnt_r, cnt_nx_s;
    logic                     frame_entry_s;

    logic [4*NUM_DIGITS-1:0]  act_data_r, pend_data_r, act_data_nx_s;
    logic [NUM_DIGITS-1:0]    act_dp_r, pend_dp_r, act_dp_nx_s;
    logic [NUM_DIGITS-1:0]    act_bm_r, pend_bm_r, act_bm_nx_s;
    logic                     load_pending_r;

    logic [NUM_DIGITS-1:0]    an_n_r, an_nx_s;
    logic [7:0]               seg_n_r, seg_nx_s;
    logic                     frame_start_r;

    logic [3:0]               digit_s;
    logic [6:0]               font_n_s;

    // Slot sequencing: blank phase, show phase, digit advance and frame wrap
    always_comb begin
        state_nx_s    = state_r;
        idx_nx_s      = idx_r;
        cnt_nx_s      = cnt_r;
        frame_entry_s = 1'b0;
        if (!en) begin
            state_nx_s = ST_IDLE;
            idx_nx_s   = '0;
            cnt_nx_s   = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nx_s    = SLOT_ENTRY;
                    idx_nx_s      = '0;
                    cnt_nx_s      = '0;
                    frame_entry_s = 1'b1;
                end
                ST_BLANK: begin
                    cnt_nx_s = cnt_r + CNT_W'(1);
                    if (cnt_r == BLANK_LAST) begin
                        state_nx_s = ST_SHOW;
                    end else begin
                        state_nx_s = ST_BLANK;
                    end
                end
                ST_SHOW: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_nx_s   = '0;
                        state_nx_s = SLOT_ENTRY;
                        if (idx_r == IDX_LAST) begin
                            idx_nx_s      = '0;
                            frame_entry_s = 1'b1;
                        end else begin
                            idx_nx_s = idx_r + IDX_W'(1);
                        end
                    end else begin
                        cnt_nx_s = cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                    idx_nx_s   = '0;
                    cnt_nx_s   = '0;
                end
            endcase
        end
    end

    // Buffer contents visible in the next cycle: pending lands at frame entry
    always_comb begin
        if (frame_entry_s) begin
            act_data_nx_s = pend_data_r;
            act_dp_nx_s   = pend_dp_r;
            act_bm_nx_s   = pend_bm_r;
        end else begin
            act_data_nx_s = act_data_r;
            act_dp_nx_s   = act_dp_r;
            act_bm_nx_s   = act_bm_r;
        end
    end

    always_comb begin
        digit_s = act_data_nx_s[{idx_nx_s, 2'b00} +: 4];
    end

    seg7_hex_decode u_decode (
        .value (digit_s),
        .seg_n (font_n_s)
    );

    // Output drive for the next cycle; masked digits keep their anode strobe
    always_comb begin
        an_nx_s  = '1;
        seg_nx_s = SEG_OFF;
        if (state_nx_s == ST_SHOW) begin
            an_nx_s[idx_nx_s] = 1'b0;
            if (act_bm_nx_s[idx_nx_s]) begin
                seg_nx_s = SEG_OFF;
            end else begin
                seg_nx_s = {~act_dp_nx_s[idx_nx_s], font_n_s};
            end
        end else begin
            an_nx_s  = '1;
            seg_nx_s = SEG_OFF;
        end
    end

    // Scanner state, buffers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            idx_r          <= '0;
            cnt_r          <= '0;
            act_data_r     <= '0;
            act_dp_r       <= '0;
            act_bm_r       <= '0;
            pend_data_r    <= '0;
            pend_dp_r      <= '0;
            pend_bm_r      <= '0;
            load_pending_r <= 1'b0;
            an_n_r         <= '1;
            seg_n_r        <= SEG_OFF;
            frame_start_r  <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            idx_r         <= idx_nx_s;
            cnt_r         <= cnt_nx_s;
            act_data_r    <= act_data_nx_s;
            act_dp_r      <= act_dp_nx_s;
            act_bm_r      <= act_bm_nx_s;
            an_n_r        <= an_nx_s;
            seg_n_r       <= seg_nx_s;
            frame_start_r <= frame_entry_s;
            // A load coinciding with the frame apply stays pending for the next frame
            if (load) begin
                pend_data_r    <= digit_data;
                pend_dp_r      <= dp;
                pend_bm_r      <= blank_mask;
                load_pending_r <= 1'b1;
            end else if (frame_entry_s) begin
                load_pending_r <= 1'b0;
            end else begin
                load_pending_r <= load_pending_r;
            end
        end
    end

    assign an_n         = an_n_r;
    assign seg_n        = seg_n_r;
    assign frame_start  = frame_start_r;
    assign load_pending = load_pending_r;

endmodule

// File: tb/tb_disp_scan_driver.sv
// Self-checking bench for disp_scan_driver: directed steps plus random loads
// and enable drops, compared every cycle against a time-based display model.
module tb_disp_scan_driver;

    localparam int ND = 4;
    localparam int CD = 8;
    localparam int BL = 2;
    localparam int FRAME = ND * CD;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic [4*ND-1:0] digit_data;
    logic [ND-1:0]   dp;
    logic [ND-1:0]   blank_mask;
    logic            load;
    logic [ND-1:0]   an_n;
    logic [7:0]      seg_n;
    logic            frame_start;
    logic            load_pending;

    int errors = 0;
    int checks = 0;

    // model: run flag, cycle offset within frame, buffers
    bit              m_run;
    int              m_t;
    bit              m_fs;
    bit              m_lp;
    logic [4*ND-1:0] p_d, a_d;
    logic [ND-1:0]   p_dp, a_dp, p_bm, a_bm;

    disp_scan_driver #(.NUM_DIGITS(ND), .CLK_DIV(CD), .BLANK_CYCLES(BL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .digit_data   (digit_data),
        .dp           (dp),
        .blank_mask   (blank_mask),
        .load         (load),
        .an_n         (an_n),
        .seg_n        (seg_n),
        .frame_start  (frame_start),
        .load_pending (load_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string lit_segs(input int v);
        case (v)
            0:  return "abcdef";
            1:  return "bc";
            2:  return "abdeg";
            3:  return "abcdg";
            4:  return "bcfg";
            5:  return "acdfg";
            6:  return "acdefg";
            7:  return "abc";
            8:  return "abcdefg";
            9:  return "abcdfg";
            10: return "abcefg";
            11: return "cdefg";
            12: return "adef";
            13: return "bcdeg";
            14: return "adefg";
            default: return "aefg";
        endcase
    endfunction

    function automatic logic [6:0] glyph_n(input int v);
        logic [6:0] g = 7'h7F;
        string s = lit_segs(v);
        for (int i = 0; i < s.len(); i++) begin
            g[int'(s.getc(i)) - 97] = 1'b0;
        end
        return g;
    endfunction

    function automatic bit m_showing();
        return m_run && ((m_t % CD) >= BL);
    endfunction

    function automatic int m_slot();
        return m_t / CD;
    endfunction

    function automatic logic [7:0] exp_an();
        logic [ND-1:0] a = '1;
        if (m_showing()) a[m_slot()] = 1'b0;
        return {{(8-ND){1'b0}}, a};
    endfunction

    function automatic logic [7:0] exp_seg();
        int s = m_slot();
        if (!m_showing() || a_bm[s]) return 8'hFF;
        return {~a_dp[s], glyph_n(int'(a_d[4*s +: 4]))};
    endfunction

    task automatic model_reset();
        m_run = 0; m_t = 0; m_fs = 0; m_lp = 0;
        p_d = '0; a_d = '0; p_dp = '0; a_dp = '0; p_bm = '0; a_bm = '0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else begin
            m_fs = 0;
            if (!en) begin
                m_run = 0; m_t = 0;
            end else if (!m_run) begin
                m_run = 1; m_t = 0; m_fs = 1;
            end else begin
                m_t = (m_t + 1) % FRAME;
                m_fs = (m_t == 0);
            end
            if (m_fs) begin
                a_d = p_d; a_dp = p_dp; a_bm = p_bm; m_lp = 0;
            end
            if (load) begin
                p_d = digit_data; p_dp = dp; p_bm = blank_mask; m_lp = 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("an_n", {{(8-ND){1'b0}}, an_n}, exp_an());
        chk("seg_n", seg_n, exp_seg());
        chk("frame_start", {7'b0, frame_start}, {7'b0, m_fs});
        chk("load_pending", {7'b0, load_pending}, {7'b0, m_lp});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input logic [4*ND-1:0] d, input logic [ND-1:0] p, input logic [ND-1:0] b);
        digit_data = d; dp = p; blank_mask = b; load = 1'b1;
        step();
        load = 1'b0;
        digit_data = 16'($urandom); dp = 4'($urandom); blank_mask = 4'($urandom);
    endtask

    task automatic wait_show(input int slot, input string tag);
        int n = 0;
        while (!(m_showing() && m_slot() == slot) && n < 200) begin
            step();
            n++;
        end
        checks++;
        assert (n < 200) else begin
            errors++;
            $error("FAIL %s: timeout waiting for slot %0d show", tag, slot);
        end
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0; en = 1'b1; load = 1'b0;
        digit_data = 16'h0; dp = 4'h0; blank_mask = 4'h0;

        // reset held with en high: dark, no frame_start
        run(5);

        rst_n = 1'b1; en = 1'b0;
        do_load(16'h1234, 4'h0, 4'h0);
        chk("lp_after_load", {7'b0, load_pending}, 8'h01);

        en = 1'b1;
        step();
        chk("first_frame_start", {7'b0, frame_start}, 8'h01);
        chk("first_blank_an", {4'h0, an_n}, 8'h0F);
        step();
        step();
        chk("digit0_an", {4'h0, an_n}, 8'h0E);
        chk("digit0_seg4", seg_n, 8'h99);
        run(2 * FRAME - 3);

        // two loads in one frame, last wins at next frame
        wait_show(1, "wait_digit1");
        do_load(16'h5678, 4'($urandom), 4'h0);
        run(3);
        do_load(16'h9ABC, 4'h0, 4'h0);
        run(2 * FRAME);

        // blanked digit 2 keeps anode strobe; dp on digit 0
        do_load(16'($urandom), 4'b0001, 4'b0100);
        run(2 * FRAME + 5);

        // enable drop mid digit 2 and restart
        wait_show(2, "wait_digit2");
        en = 1'b0;
        step();
        chk("en_drop_dark", {4'h0, an_n}, 8'h0F);
        run(3);
        en = 1'b1;
        step();
        chk("reenable_fs", {7'b0, frame_start}, 8'h01);
        run(FRAME + 4);

        // random loads and rare enable drops
        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 9) == 0) begin
                do_load(16'($urandom), 4'($urandom), 4'($urandom));
            end else begin
                step();
            end
        end

        // asynchronous reset in the middle of a show phase
        en = 1'b1;
        do_load(16'hFEDC, 4'hF, 4'h0);
        wait_show(1, "wait_reset_point");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        run(2);
        rst_n = 1'b1;
        run(FRAME + 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
